// File: rtl/ee354_2048_move_input.sv
// Button front end for the 2048 game. It synchronizes and debounces four push-buttons,
// then arbitrates them into single-cycle move pulses with a hold-off until all buttons are released.
module ee354_2048_move_input #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [3:0] held,
  output logic       locked,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    LOCK  = 2'd2
  } state_t;

  localparam logic [15:0] CNT_MAX = DB_CYCLES - 16'd1;

  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] level;
  logic [3:0] level_q;
  logic [3:0] rise;
  logic [3:0] move_d;
  logic [3:0] move_q;
  state_t     state;
  state_t     state_d;

  // Bit order is {U,D,L,R} everywhere, so bit 3 has the highest priority.
  assign raw = {BtnU, BtnD, BtnL, BtnR};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // One debouncer per button: the level flips only after DB_CYCLES
  // consecutive synchronized samples disagree with it.
  for (genvar b = 0; b < 4; b++) begin : g_db
    logic [15:0] cnt;
    logic        lvl;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[b] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end

    assign level[b] = lvl;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      level_q <= '0;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      move_q <= '0;
    end else begin
      state  <= state_d;
      move_q <= move_d;
    end
  end

  // Rises seen outside IDLE are dropped; LOCK waits for every button to be released.
  always_comb begin
    state_d = state;
    move_d  = '0;
    case (state)
      IDLE: begin
        if (rise != 4'b0000) begin
          state_d = PULSE;
          if (rise[3])      move_d = 4'b1000;
          else if (rise[2]) move_d = 4'b0100;
          else if (rise[1]) move_d = 4'b0010;
          else              move_d = 4'b0001;
        end
      end
      PULSE: begin
        state_d = LOCK;
      end
      LOCK: begin
        if (level == 4'b0000) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign {up, down, left, right} = move_q;
  assign held      = level;
  assign locked    = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_ee354_2048_move_input.sv
// Bench for ee354_2048_move_input with DB_CYCLES=4: a window-based reference model checked every
// cycle, directed scenarios with literal pulse timings, then randomized button activity.
module tb_ee354_2048_move_input;

  localparam int DB    = 4;
  localparam int MAXC  = 16384;

  logic       clk;
  logic       rst;
  logic       btn_u, btn_d, btn_l, btn_r;
  logic       up, down, left, right;
  logic [3:0] held;
  logic       locked;
  logic [1:0] fsm_state;

  int compared   = 0;
  int mismatched = 0;

  ee354_2048_move_input #(.DB_CYCLES(16'd4)) dut (
    .Clk(clk), .Reset(rst),
    .BtnU(btn_u), .BtnD(btn_d), .BtnL(btn_l), .BtnR(btn_r),
    .up(up), .down(down), .left(left), .right(right),
    .held(held), .locked(locked), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: edge-indexed history of raw samples. The synchronized sample seen
  // by a debouncer at edge t is the raw sample of edge t-2 (zero if reset intervened).
  // A level flips at edge t when the last DB synchronized samples since the previous
  // flip/reset all disagree with it.
  int  cyc = 0;
  int  rst_last = 0;
  int  last_tog [4];
  bit  rawh [4][MAXC];
  bit  s2h  [4][MAXC];
  logic [3:0] m_lvl = '0;
  logic [3:0] m_prev = '0;
  logic [3:0] m_move = '0;
  logic       m_locked = 1'b0;

  initial for (int b = 0; b < 4; b++) last_tog[b] = 0;

  always @(posedge clk) begin
    logic [3:0] rnow;
    logic [3:0] rise;
    bit ok;
    int e;
    cyc = cyc + 1;
    rnow = {btn_u, btn_d, btn_l, btn_r};
    for (int b = 0; b < 4; b++) rawh[b][cyc] = rnow[b];
    if (rst) begin
      rst_last = cyc;
      m_lvl = '0; m_prev = '0; m_move = '0; m_locked = 1'b0;
      for (int b = 0; b < 4; b++) last_tog[b] = cyc;
    end else begin
      for (int b = 0; b < 4; b++)
        s2h[b][cyc] = (cyc - 2 > rst_last) ? rawh[b][cyc-2] : 1'b0;
      rise = m_lvl & ~m_prev;
      if (!m_locked && rise != 4'b0000) begin
        m_locked = 1'b1;
        if (rise[3])      m_move = 4'b1000;
        else if (rise[2]) m_move = 4'b0100;
        else if (rise[1]) m_move = 4'b0010;
        else              m_move = 4'b0001;
      end else begin
        m_move = '0;
        if (m_locked && m_lvl == 4'b0000) m_locked = 1'b0;
      end
      m_prev = m_lvl;
      for (int b = 0; b < 4; b++) begin
        ok = 1'b1;
        for (int j = 0; j < DB; j++) begin
          e = cyc - j;
          if (e <= last_tog[b] || s2h[b][e] == m_lvl[b]) ok = 1'b0;
        end
        if (ok) begin
          m_lvl[b] = ~m_lvl[b];
          last_tog[b] = cyc;
        end
      end
    end
  end

  // Scoreboard: DUT pulses observed, queued with their edge index and direction.
  int         pulse_edge [$];
  logic [3:0] pulse_dir  [$];
  bit         held_seen;
  bit         locked_seen;

  always @(negedge clk) begin
    logic [3:0] mv;
    mv = {up, down, left, right};
    if (cyc > 0) begin
      compared++;
      if (mv !== m_move) begin
        mismatched++;
        $display("FAIL moves @edge %0d: got %b want %b", cyc, mv, m_move);
      end
      compared++;
      if (held !== m_lvl) begin
        mismatched++;
        $display("FAIL held @edge %0d: got %b want %b", cyc, held, m_lvl);
      end
      compared++;
      if (locked !== m_locked) begin
        mismatched++;
        $display("FAIL locked @edge %0d: got %b want %b", cyc, locked, m_locked);
      end
      compared++;
      if ($countones(mv) > 1) begin
        mismatched++;
        $display("FAIL onehot @edge %0d: got %b want at most one bit", cyc, mv);
      end
    end
    if (mv != 4'b0000) begin
      pulse_edge.push_back(cyc);
      pulse_dir.push_back(mv);
    end
    if (held != 4'b0000) held_seen = 1'b1;
    if (locked) locked_seen = 1'b1;
  end

  // Driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btns(input logic [3:0] v);
    {btn_u, btn_d, btn_l, btn_r} = v;
  endtask

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    pulse_edge.delete();
    pulse_dir.delete();
    held_seen = 1'b0;
    locked_seen = 1'b0;
  endtask

  task automatic check_pulse(input string name, input int idx, input int edge_exp,
                             input logic [3:0] dir_exp);
    if (pulse_edge.size() > idx) begin
      check({name, "_edge"}, pulse_edge[idx], edge_exp);
      check({name, "_dir"}, int'(pulse_dir[idx]), int'(dir_exp));
    end else begin
      check({name, "_present"}, pulse_edge.size(), idx + 1);
    end
  endtask

  int n;
  int f;

  initial begin
    rst = 1'b1;
    set_btns(4'b0000);
    clear_log();
    cycles(3);
    check("reset_held", int'(held), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_moves", int'({up, down, left, right}), 0);
    check("reset_state", int'(fsm_state), 0);
    rst = 1'b0;
    cycles(5);

    // Clean press of U
    clear_log();
    set_btns(4'b1000); n = cyc + 1;
    cycles(12);
    set_btns(4'b0000);
    cycles(20);
    check("clean_count", pulse_edge.size(), 1);
    check_pulse("clean", 0, n + 6, 4'b1000);

    // Bouncing L, then stable
    clear_log();
    set_btns(4'b0010); cycles(1);
    set_btns(4'b0000); cycles(1);
    set_btns(4'b0010); cycles(1);
    set_btns(4'b0000); cycles(1);
    set_btns(4'b0010); f = cyc + 1;
    cycles(15);
    set_btns(4'b0000);
    cycles(20);
    check("bounce_count", pulse_edge.size(), 1);
    check_pulse("bounce", 0, f + 6, 4'b0010);

    // Simultaneous D and R
    clear_log();
    set_btns(4'b0101); n = cyc + 1;
    cycles(30);
    set_btns(4'b0000);
    cycles(20);
    check("simul_count", pulse_edge.size(), 1);
    check_pulse("simul", 0, n + 6, 4'b0100);

    // Held lockout: R held, then U added
    clear_log();
    set_btns(4'b0001); n = cyc + 1;
    cycles(100);
    set_btns(4'b1001);
    cycles(30);
    set_btns(4'b0000);
    cycles(20);
    check("lockout_count", pulse_edge.size(), 1);
    check_pulse("lockout", 0, n + 6, 4'b0001);
    set_btns(4'b1000); n = cyc + 1;
    cycles(12);
    set_btns(4'b0000);
    cycles(20);
    check("lockout_after_count", pulse_edge.size(), 2);
    check_pulse("lockout_after", 1, n + 6, 4'b1000);

    // Reset mid-count: D pressed, one-cycle reset after two counted samples
    clear_log();
    set_btns(4'b0100); n = cyc + 1;
    cycles(4);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(15);
    set_btns(4'b0000);
    cycles(20);
    check("rstmid_count", pulse_edge.size(), 1);
    check_pulse("rstmid", 0, n + 11, 4'b0100);

    // Glitch rejection: L high for only three samples
    clear_log();
    set_btns(4'b0010);
    cycles(3);
    set_btns(4'b0000);
    cycles(20);
    check("glitch_count", pulse_edge.size(), 0);
    check("glitch_held", int'(held_seen), 0);
    check("glitch_locked", int'(locked_seen), 0);

    // Randomized activity, checked every cycle against the model
    while (cyc < 4000) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        cycles($urandom_range(1, 3));
        rst = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) set_btns(4'b0000);
        else set_btns(4'($urandom_range(0, 15)));
        if ($urandom_range(0, 4) == 0) cycles($urandom_range(8, 40));
        else cycles($urandom_range(1, 6));
      end
    end
    set_btns(4'b0000);
    cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
